ioctl_mem_sched: RTL and testbench
==================================

Name: ioctl_mem_sched

Overview:
- Schedules one shared single-port RAM between two requesters: the ioctl download stream (ROM/disk image load from the HPS/sim harness) and the emulated CPU.
- Download writes take priority. ioctl_wait applies backpressure to the download stream.
- Generates core_reset: the core is held in reset during a matching download and for a fixed stretch after it ends.
- Sits between the top-level ioctl bus and the sharpx1 core memory.

Parameters:
- ADDR_W, 16: RAM address width. Downloads to ioctl_addr >= 2**ADDR_W are discarded.
- DL_INDEX, 8'h00: ioctl_index value that targets this RAM. Other indexes are ignored entirely.
- RST_HOLD, 16: cycles core_reset stays high after a matching download ends (1..255).
- MEM_LAT, 1: RAM read latency in cycles (1 or 2).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download in progress
- ioctl_index  in  8  download target select
- ioctl_wr  in  1  one-cycle strobe, byte valid
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  backpressure to download source
- cpu_req  in  1  CPU access request, level; held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  CPU address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_din  out  8  RAM write data
- mem_dout  in  8  RAM read data
- core_reset  out  1  reset to emulated core
- dl_overflow  out  1  sticky: strobe arrived while ioctl_wait=1

Behaviour:
- Reset values: ioctl_wait=0, cpu_ack=0, cpu_dout=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, core_reset=1, dl_overflow=0. Internal state: pending=0, hold counter=RST_HOLD, FSM=IDLE.
- dl_active = ioctl_download && ioctl_index==DL_INDEX.
- Pending buffer (1 deep):
  - Captures addr/data when ioctl_wr && dl_active && pending==0.
  - ioctl_wait is registered; it equals pending is set or next-state pending is set.
  - A strobe while pending==1 is dropped and sets dl_overflow.
  - dl_overflow clears only on reset or on a new dl_active rising edge.
- Out-of-range address (ioctl_addr[24:ADDR_W] != 0): the byte is accepted without wait. No RAM write is issued.
- FSM states:
  - IDLE: if pending, issue the write that cycle (mem_en=1, mem_we=1); pending clears next cycle. Download has priority even mid-request. Else if cpu_req && !dl_active && !core_reset: for a write, issue the RAM write, pulse cpu_ack next cycle, return to IDLE; for a read, issue the RAM read and go to RD_WAIT.
  - RD_WAIT: wait MEM_LAT cycles, then latch mem_dout into cpu_dout, pulse cpu_ack, go to IDLE. A download strobe during RD_WAIT sets pending and raises wait; it is serviced on return to IDLE.
- One RAM access per cycle maximum. mem_en is low when idle.
- cpu_ack is never asserted while dl_active=1. CPU requests stall; they are not dropped.
- core_reset = reset | dl_active | (hold counter != 0).
  - On the falling edge of dl_active, load the hold counter with RST_HOLD.
  - The counter decrements to 0 and saturates there.
  - A new dl_active restarts the sequence.
- Reset asserted mid-operation: the pending byte is discarded, any in-flight read is abandoned with no cpu_ack, and the FSM goes to IDLE.
- Simultaneous CPU request and ioctl strobe in IDLE with pending=0: the strobe is captured, the CPU is not granted that cycle (dl_active blocks it), and the write is issued next cycle.

Optional Feature:
- Macro: IOCTL_CHECKSUM_EN.
- Defined:
  - Adds output dl_sum [15:0]: a 16-bit wrapping sum of every in-range byte actually written to RAM by downloads.
  - Clears on the rising edge of dl_active; holds its value after the download ends.
  - Reset value 0.
- Undefined: the port and adder are absent. All other behaviour is identical.

Test Plan:
- Reset with reset=1 for 3 cycles: all outputs at reset values and core_reset=1. Release with no download: core_reset still high until the hold counter is 0, i.e. low RST_HOLD=16 cycles after release.
- Download DL_INDEX, 4 strobes spaced 2 cycles, addr 0..3, data A5,5A,FF,00: four RAM writes observed. Each mem_we occurs 1 cycle after its strobe, ioctl_wait never blocks a strobe, and core_reset falls exactly 16 cycles after ioctl_download falls. With IOCTL_CHECKSUM_EN, dl_sum=0x01FE.
- Strobe on back-to-back cycles: first accepted; second arrives while wait=1, so it is dropped and dl_overflow=1 with no second RAM write. dl_overflow clears at the next download start.
- CPU read at addr 0x1234 holding 0x3C, MEM_LAT=1: mem_en one cycle after req, cpu_ack with cpu_dout=0x3C two cycles after req. A CPU write of 0x77 gets ack 1 cycle after issue.
- Index mismatch (ioctl_index=8'h01) download: no RAM writes, ioctl_wait=0, core_reset unaffected.
- ioctl_addr=0x10000 with ADDR_W=16: no mem_we, no wait. Reset asserted during RD_WAIT: no cpu_ack, FSM back in IDLE.

Source files
------------

// File: rtl/ioctl_mem_sched_if.sv
// ioctl_mem_sched_if: bundles the download bus, the CPU request bus and the
// shared RAM port of ioctl_mem_sched.
// slave  = scheduler view, master = surrounding system view.
// IOCTL_CHECKSUM_EN adds the dl_sum output.
interface ioctl_mem_sched_if #(
    parameter int ADDR_W = 16
) ();
    // download stream
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    // CPU requester
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;
    // shared RAM port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    // status
    logic              core_reset;
    logic              dl_overflow;
`ifdef IOCTL_CHECKSUM_EN
    logic [15:0]       dl_sum;
`endif

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout,
`ifdef IOCTL_CHECKSUM_EN
        output dl_sum,
`endif
        output core_reset, dl_overflow
    );

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout,
`ifdef IOCTL_CHECKSUM_EN
        input  dl_sum,
`endif
        input  core_reset, dl_overflow
    );
endinterface

// File: rtl/ioctl_mem_sched.sv
// ioctl_mem_sched: arbitrates one single-port RAM between the ioctl download
// stream (priority) and the emulated CPU, and generates the core reset.
// Optional feature macro: IOCTL_CHECKSUM_EN (adds dl_sum, a 16-bit wrapping
// sum of all download bytes written to RAM).
//
// Timing: RAM controls are registered. A read launched at clock edge E has
// mem_dout sampled at edge E+MEM_LAT, so with MEM_LAT=1 the RAM must present
// data in the cycle mem_en is high. A download byte stays "pending" (and
// ioctl_wait high) until its RAM write cycle has completed, so a strobe on
// the very next cycle is dropped and flagged in dl_overflow.
module ioctl_mem_sched #(
    parameter int         ADDR_W   = 16,
    parameter logic [7:0] DL_INDEX = 8'h00,
    parameter int         RST_HOLD = 16,
    parameter int         MEM_LAT  = 1
) (
    input logic              clk_sys,
    input logic              reset,
    ioctl_mem_sched_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);
    localparam logic [1:0] LAT_LAST  = 2'(MEM_LAT - 1);

    state_t            state_r;
    logic              pending_r;
    logic              dl_issued_r;
    logic              dl_active_d_r;
    logic              cpu_done_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [7:0]        pend_data_r;
    logic [7:0]        hold_r;
    logic [1:0]        lat_r;

    logic dl_active_s;
    logic dl_rise_s;
    logic in_range_s;
    logic accept_s;
    logic drop_s;
    logic launch_pend_s;
    logic launch_new_s;
    logic grant_s;
    logic pending_next_s;
    logic core_reset_s;

    // Request decode: download match, acceptance and CPU grant for this cycle.
    always_comb begin
        dl_active_s   = bus.ioctl_download && (bus.ioctl_index == DL_INDEX);
        dl_rise_s     = dl_active_s && !dl_active_d_r;
        in_range_s    = (bus.ioctl_addr[24:ADDR_W] == {(25 - ADDR_W){1'b0}});
        accept_s      = bus.ioctl_wr && dl_active_s && !pending_r;
        drop_s        = bus.ioctl_wr && dl_active_s && pending_r;
        launch_pend_s = (state_r == IDLE) && pending_r && !dl_issued_r;
        launch_new_s  = (state_r == IDLE) && accept_s && in_range_s;
        core_reset_s  = reset || dl_active_s || (hold_r != 8'd0);
        grant_s       = (state_r == IDLE) && !pending_r && !launch_new_s &&
                        bus.cpu_req && !dl_active_s && !core_reset_s &&
                        !cpu_done_r && !bus.cpu_ack;
        if (dl_issued_r) begin
            pending_next_s = 1'b0;
        end else if (accept_s && in_range_s) begin
            pending_next_s = 1'b1;
        end else begin
            pending_next_s = pending_r;
        end
    end

    assign bus.core_reset = core_reset_s;

    // Scheduler FSM, pending buffer, hold counter and all registered outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r         <= IDLE;
            pending_r       <= 1'b0;
            dl_issued_r     <= 1'b0;
            dl_active_d_r   <= 1'b0;
            cpu_done_r      <= 1'b0;
            pend_addr_r     <= {ADDR_W{1'b0}};
            pend_data_r     <= 8'd0;
            hold_r          <= HOLD_INIT;
            lat_r           <= 2'd0;
            bus.ioctl_wait  <= 1'b0;
            bus.cpu_ack     <= 1'b0;
            bus.cpu_dout    <= 8'd0;
            bus.mem_en      <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= {ADDR_W{1'b0}};
            bus.mem_din     <= 8'd0;
            bus.dl_overflow <= 1'b0;
        end else begin
            dl_active_d_r  <= dl_active_s;
            pending_r      <= pending_next_s;
            bus.ioctl_wait <= pending_next_s;
            dl_issued_r    <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.cpu_ack    <= 1'b0;

            if (accept_s && in_range_s) begin
                pend_addr_r <= bus.ioctl_addr[ADDR_W-1:0];
                pend_data_r <= bus.ioctl_dout;
            end else begin
                pend_addr_r <= pend_addr_r;
            end

            if (drop_s) begin
                bus.dl_overflow <= 1'b1;
            end else if (dl_rise_s) begin
                bus.dl_overflow <= 1'b0;
            end else begin
                bus.dl_overflow <= bus.dl_overflow;
            end

            // counter sits at RST_HOLD while downloading, counts down after
            if (dl_active_s) begin
                hold_r <= HOLD_INIT;
            end else if (hold_r != 8'd0) begin
                hold_r <= hold_r - 8'd1;
            end else begin
                hold_r <= hold_r;
            end

            // completed CPU access whose ack was held off by a download
            if (cpu_done_r && !dl_active_s) begin
                bus.cpu_ack <= 1'b1;
                cpu_done_r  <= 1'b0;
            end else begin
                cpu_done_r  <= cpu_done_r;
            end

            case (state_r)
                IDLE: begin
                    if (launch_pend_s) begin
                        bus.mem_en   <= 1'b1;
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= pend_addr_r;
                        bus.mem_din  <= pend_data_r;
                        dl_issued_r  <= 1'b1;
                    end else if (launch_new_s) begin
                        bus.mem_en   <= 1'b1;
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= bus.ioctl_addr[ADDR_W-1:0];
                        bus.mem_din  <= bus.ioctl_dout;
                        dl_issued_r  <= 1'b1;
                    end else if (grant_s) begin
                        bus.mem_en   <= 1'b1;
                        bus.mem_we   <= bus.cpu_we;
                        bus.mem_addr <= bus.cpu_addr;
                        bus.mem_din  <= bus.cpu_din;
                        if (bus.cpu_we) begin
                            cpu_done_r <= 1'b1;
                        end else begin
                            lat_r   <= 2'd0;
                            state_r <= RD_WAIT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (lat_r == LAT_LAST) begin
                        bus.cpu_dout <= bus.mem_dout;
                        state_r      <= IDLE;
                        if (dl_active_s) begin
                            cpu_done_r  <= 1'b1;
                        end else begin
                            bus.cpu_ack <= 1'b1;
                        end
                    end else begin
                        lat_r <= lat_r + 2'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef IOCTL_CHECKSUM_EN
    logic [7:0] sum_byte_s;
    logic [15:0] sum_base_s;

    // Selects the byte being written this cycle and the restart-aware base.
    always_comb begin
        if (launch_pend_s) begin
            sum_byte_s = pend_data_r;
        end else begin
            sum_byte_s = bus.ioctl_dout;
        end
        if (dl_rise_s) begin
            sum_base_s = 16'd0;
        end else begin
            sum_base_s = bus.dl_sum;
        end
    end

    // Running sum of download bytes written to RAM, restarted per download.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bus.dl_sum <= 16'd0;
        end else if (launch_pend_s || launch_new_s) begin
            bus.dl_sum <= sum_base_s + {8'd0, sum_byte_s};
        end else begin
            bus.dl_sum <= sum_base_s;
        end
    end
`endif
endmodule

// File: tb/tb_ioctl_mem_sched.sv
// Scoreboard bench for ioctl_mem_sched: stimulus pushes expected RAM
// accesses and CPU acks (with the cycle they must appear in); a monitor on
// the falling edge pops and compares whenever the DUT presents one.
module tb_ioctl_mem_sched;
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       chk_data;
        int         cyc;
    } ack_exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];
    logic [7:0] ram [65536];
    logic [7:0] pat [4];

    ioctl_mem_sched_if #(.ADDR_W(16)) bus ();

    ioctl_mem_sched #(
        .ADDR_W(16), .DL_INDEX(8'h00), .RST_HOLD(16), .MEM_LAT(1)
    ) dut (
        .clk_sys(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: synchronous write, read data follows mem_addr
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    end
    assign bus.mem_dout = ram[bus.mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: compare every RAM access and CPU ack against the scoreboard
    always @(negedge clk) begin
        mem_exp_t me;
        ack_exp_t ae;
        if (bus.mem_en === 1'b1) begin
            if (mem_q.size() == 0) begin
                chk("mem_unexpected_addr", {16'd0, bus.mem_addr}, 32'hFFFF_FFFF);
            end else begin
                me = mem_q.pop_front();
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, me.we});
                chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, me.addr});
                chk("mem_cycle", cyc, me.cyc);
                if (me.we) chk("mem_din", {24'd0, bus.mem_din}, {24'd0, me.data});
            end
        end
        if (bus.cpu_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                chk("ack_unexpected", {31'd0, bus.cpu_ack}, 32'd0);
            end else begin
                ae = ack_q.pop_front();
                chk("ack_cycle", cyc, ae.cyc);
                if (ae.chk_data) chk("cpu_dout", {24'd0, bus.cpu_dout}, {24'd0, ae.data});
            end
        end
    end

    task automatic cpu_access(input logic we, input logic [15:0] a,
                              input logic [7:0] d, input logic [7:0] exp_rd);
        int  n;
        bit  got;
        n = cyc;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = a;
        bus.cpu_din  = d;
        mem_q.push_back('{we, a, d, n + 1});
        ack_q.push_back('{exp_rd, !we, n + 2});
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick(1);
            if (bus.cpu_ack === 1'b1) got = 1'b1;
        end
        bus.cpu_req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL cpu_ack_timeout actual=none required=ack addr=%0h", a);
        end
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int s;
        pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'hFF; pat[3] = 8'h00;
        reset = 1'b1;
        bus.ioctl_download = 1'b0; bus.ioctl_index = 8'h00; bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = 25'd0; bus.ioctl_dout = 8'd0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'd0; bus.cpu_din = 8'd0;

        // reset values
        tick(3);
        chk("rst_ioctl_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        chk("rst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
        chk("rst_cpu_dout", {24'd0, bus.cpu_dout}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_din", {24'd0, bus.mem_din}, 32'd0);
        chk("rst_core_reset", {31'd0, bus.core_reset}, 32'd1);
        chk("rst_dl_overflow", {31'd0, bus.dl_overflow}, 32'd0);
        reset = 1'b0;
        tick(15);
        chk("post_rst_hold_high", {31'd0, bus.core_reset}, 32'd1);
        tick(1);
        chk("post_rst_hold_low", {31'd0, bus.core_reset}, 32'd0);

        // download of four bytes, strobes spaced two cycles
        bus.ioctl_index = 8'h00;
        bus.ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            chk("dl_wait_before_strobe", {31'd0, bus.ioctl_wait}, 32'd0);
            chk("dl_core_reset", {31'd0, bus.core_reset}, 32'd1);
            bus.ioctl_wr = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = pat[i];
            mem_q.push_back('{1'b1, 16'(i), pat[i], cyc + 1});
            tick(1);
            chk("dl_wait_after_strobe", {31'd0, bus.ioctl_wait}, 32'd1);
            bus.ioctl_wr = 1'b0;
            tick(1);
        end
        tick(2);
        bus.ioctl_download = 1'b0;
        tick(15);
        chk("dl_end_hold_high", {31'd0, bus.core_reset}, 32'd1);
        tick(1);
        chk("dl_end_hold_low", {31'd0, bus.core_reset}, 32'd0);
`ifdef IOCTL_CHECKSUM_EN
        chk("dl_sum", {16'd0, bus.dl_sum}, 32'h0000_01FE);
`endif

        // back-to-back strobes: second is dropped and flagged
        bus.ioctl_download = 1'b1;
        tick(1);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd16; bus.ioctl_dout = 8'h11;
        mem_q.push_back('{1'b1, 16'd16, 8'h11, cyc + 1});
        tick(1);
        chk("b2b_wait", {31'd0, bus.ioctl_wait}, 32'd1);
        bus.ioctl_addr = 25'd17; bus.ioctl_dout = 8'h22;
        tick(1);
        bus.ioctl_wr = 1'b0;
        chk("b2b_overflow_set", {31'd0, bus.dl_overflow}, 32'd1);
        tick(2);
        bus.ioctl_download = 1'b0;
        tick(2);
        chk("b2b_overflow_sticky", {31'd0, bus.dl_overflow}, 32'd1);
        bus.ioctl_download = 1'b1;
        tick(1);
        chk("b2b_overflow_clear", {31'd0, bus.dl_overflow}, 32'd0);
        bus.ioctl_download = 1'b0;
        tick(17);

        // index mismatch: ignored completely
        bus.ioctl_index = 8'h01;
        bus.ioctl_download = 1'b1;
        tick(1);
        chk("idx_core_reset", {31'd0, bus.core_reset}, 32'd0);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd20; bus.ioctl_dout = 8'h99;
        tick(1);
        bus.ioctl_wr = 1'b0;
        chk("idx_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        tick(2);
        bus.ioctl_download = 1'b0;
        bus.ioctl_index = 8'h00;

        // out-of-range address: accepted, no wait, no RAM write
        bus.ioctl_download = 1'b1;
        tick(1);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0010000; bus.ioctl_dout = 8'h44;
        tick(1);
        bus.ioctl_wr = 1'b0;
        chk("oor_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        tick(2);
        bus.ioctl_download = 1'b0;
        tick(17);

        // CPU accesses
        cpu_access(1'b1, 16'h1234, 8'h3C, 8'h00);
        cpu_access(1'b0, 16'h1234, 8'h00, 8'h3C);
        cpu_access(1'b1, 16'h00FF, 8'h77, 8'h00);
        cpu_access(1'b0, 16'h00FF, 8'h00, 8'h77);
        cpu_access(1'b0, 16'h0001, 8'h00, 8'h5A);

        // reset during RD_WAIT: read abandoned, no ack
        s = cyc;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
        mem_q.push_back('{1'b0, 16'h1234, 8'h00, s + 1});
        tick(1);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        tick(1);
        chk("rdrst_no_ack", {31'd0, bus.cpu_ack}, 32'd0);
        chk("rdrst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        tick(1);
        reset = 1'b0;
        tick(17);
        chk("rdrst_core_reset_low", {31'd0, bus.core_reset}, 32'd0);
        cpu_access(1'b0, 16'h1234, 8'h00, 8'h3C);

        tick(3);
        chk("mem_queue_empty", mem_q.size(), 32'd0);
        chk("ack_queue_empty", ack_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
